mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Memory and memory-mapped I/O controller on the downstream side of the Simple RISC Machine CPU. It accepts single-word read and write requests over a req/ack handshake and decodes the 9-bit address onto an internal 256-word RAM, an 8-bit LED output register and an 8-bit switch input port. It returns read data with a one-cycle acknowledge, and it inserts a configurable number of RAM wait states.

## Interface
Parameters:
- RAM_WAIT, default 1: extra wait cycles on RAM accesses. Legal range 0..3.
- RAM_INIT, default "data.txt": `$readmemh` file used to initialise the RAM.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  request strobe from the CPU.
- we  in  1  1 = write, 0 = read. Sampled with req.
- addr  in  9  word address. Sampled with req.
- wdata  in  16  write data. Sampled with req.
- rdata  out  16  read data.
- ack  out  1  one-cycle transaction-complete pulse.
- busy  out  1  high whenever the controller is not in IDLE.
- sw  in  8  switch inputs.
- led  out  8  LED register.
- err  out  1  unmapped-access flag. Behaviour depends on MMIO_ERR_EN.

## Operation
Address map:
- addr[8]=0: RAM word addr[7:0]. Read and write.
- 9'h100: LED register.
  - Write: led <= wdata[7:0].
  - Read: returns {8'h00, led}.
- 9'h140: switch port.
  - Read: returns {8'h00, sw}, sampled at the ACCESS edge.
  - Write: ignored, no error.
- Any other address: unmapped (see Configuration).

FSM states are IDLE, ACCESS, WAIT and RESP.
- IDLE: when req=1, latch we, addr and wdata into internal registers; next state ACCESS. Otherwise stay in IDLE.
- ACCESS: perform the access from the latched values.
  - RAM write and LED write commit at the edge leaving ACCESS.
  - RAM read address is presented to the synchronous RAM.
  - Next state: WAIT for a RAM access with RAM_WAIT>0, otherwise RESP.
- WAIT: a 2-bit counter loaded with RAM_WAIT-1 in ACCESS counts down to 0; next state RESP.
- RESP:
  - ack=1.
  - rdata is updated with the read result at the edge entering RESP.
  - rdata is unchanged on writes.
  - Next state IDLE, unconditionally.

Handshake rules:
- req is examined only in IDLE.
- The requester deasserts req during the ack cycle unless it is issuing the next transaction. A held req is taken as a new request at the IDLE edge after RESP.
- Changes on addr, we or wdata while busy=1 have no effect.
- rdata holds its value until the next completed read.

## Timing
- Reset: state IDLE, ack=0, busy=0, rdata=16'h0000, led=8'h00, err=0. RAM contents are not cleared.
- req=1 sampled at edge E0 in IDLE:
  - ACCESS starts at E0.
  - For IO, or RAM with RAM_WAIT=0: ack is high from E0+2 to E0+3.
  - For RAM with RAM_WAIT=N>0: ack is high from E0+2+N to E0+3+N.
- Minimum spacing between back-to-back transactions is 3 cycles; busy is low for one cycle between them.
- Reset asserted mid-transaction aborts the transaction at once.
  - A write whose ACCESS exit edge has not yet occurred is not committed.
  - No ack is produced for the aborted transaction.
- A read of RAM word K in the cycle immediately after a write to K returns the new data. The RAM read occurs only after the prior write has committed.

## Configuration
Macro: MMIO_ERR_EN.
- Defined:
  - An unmapped read returns rdata=16'hDEAD.
  - Any unmapped access drives err=1 for the ack cycle only.
  - err is registered and cleared on reset.
- Undefined:
  - err is tied to 0.
  - An unmapped read returns 16'h0000.
  - An unmapped write is silently dropped.
- The address decode, state machine and latency are identical in both builds.

## Test plan
- RAM write then read (RAM_WAIT=1): write 9'h005=16'h1234, then read 9'h005. Required: ack 3 cycles after each accepted req, and rdata=16'h1234 in the read's ack cycle.
- LED write then read: write 9'h100=16'h01A5, then read 9'h100. Required: led=8'hA5 one cycle before the write's ack, and the read returns 16'h00A5.
- Switch read and write: set sw=8'h3C and read 9'h140; then write 9'h140=16'hFFFF. Required: read returns rdata=16'h003C. After the write, led and RAM are unchanged and err=0.
- Unmapped read of 9'h1FF. Required with MMIO_ERR_EN: rdata=16'hDEAD and err=1 in the ack cycle only. Required without it: rdata=16'h0000 and err=0.
- Reset abort: write 16'hBEEF to 9'h010 (previously 16'h0001), with reset pulsed in the ACCESS cycle. Required: no ack, all outputs at reset values, and a later read of 9'h010 returns 16'h0001.
- Busy isolation: during an in-flight read of 9'h020, change addr to 9'h030 and wdata to 16'h5555. Required: the result comes from 9'h020, and no write occurs.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// ---------------------------------------------------------------------------
// mem_io_ctrl
//
// Memory and memory-mapped I/O controller for the downstream side of the
// Simple RISC Machine CPU. Single-word read/write requests arrive over a
// req/ack handshake and are decoded onto:
//   - addr[8] == 0 : 256 x 16 RAM, word addr[7:0] (read/write)
//   - 9'h100       : 8-bit LED register (read/write)
//   - 9'h140       : 8-bit switch input port (read; writes ignored)
//   - otherwise    : unmapped
//
// Transaction flow: IDLE -> ACCESS -> [WAIT x RAM_WAIT, RAM only] -> RESP.
// ack and err are registered from the RESP state, so they are high in the
// cycle after RESP. That cycle is IDLE again, so a request presented in the
// ack cycle is taken at the end of it.
//
// Parameters:
//   RAM_WAIT  extra wait cycles on RAM accesses (0..3)
//   RAM_INIT  name of the RAM image file that the FPGA memory-init flow
//             attaches to the RAM array (the RTL itself never clears RAM)
//
// Build option:
//   MMIO_ERR_EN  defined   : unmapped reads return 16'hDEAD and any unmapped
//                            access raises err for the ack cycle.
//                undefined : err is tied low, unmapped reads return 16'h0000
//                            and unmapped writes are dropped.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous, active-high
//   req    in   1   request strobe (examined only in IDLE)
//   we     in   1   1 = write, 0 = read (sampled with req)
//   addr   in   9   word address (sampled with req)
//   wdata  in  16   write data (sampled with req)
//   rdata  out 16   read data, held until the next completed read
//   ack    out  1   one-cycle transaction-complete pulse
//   busy   out  1   high whenever the controller is not in IDLE
//   sw     in   8   switch inputs
//   led    out  8   LED register
//   err    out  1   unmapped-access flag
// ---------------------------------------------------------------------------
module mem_io_ctrl #(
    parameter int    RAM_WAIT = 1,
    parameter string RAM_INIT = "data.txt"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [8:0] ADDR_LED  = 9'h100;
    localparam logic [8:0] ADDR_SW   = 9'h140;
    localparam bit         HAS_WAIT  = (RAM_WAIT > 0);
    // Counter preload; with one wait cycle the counter starts at zero.
    localparam logic [1:0] WAIT_LOAD = HAS_WAIT ? 2'(RAM_WAIT - 1) : 2'd0;

`ifdef MMIO_ERR_EN
    localparam logic [15:0] UNMAPPED_RDATA = 16'hDEAD;
`else
    localparam logic [15:0] UNMAPPED_RDATA = 16'h0000;
`endif

    // Reject an out-of-range wait setting or an empty RAM image name.
    if (RAM_WAIT < 0 || RAM_WAIT > 3 || RAM_INIT == "") begin : g_param_check
        $error("mem_io_ctrl: RAM_WAIT must be 0..3 and RAM_INIT must name a RAM image");
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        we_q,    we_d;
    logic [8:0]  addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  led_q,   led_d;
    logic        ack_q,   ack_d;
    logic        busy_q,  busy_d;

    logic [15:0] mem_q [0:255];

    // Decode of the latched address; the live bus is never decoded.
    logic        is_ram_s;
    logic        is_led_s;
    logic        is_sw_s;
    logic        ram_we_s;
    logic [15:0] rd_val_s;

    assign is_ram_s = ~addr_q[8];
    assign is_led_s = (addr_q == ADDR_LED);
    assign is_sw_s  = (addr_q == ADDR_SW);

    // RAM writes commit on the edge leaving ACCESS. An asynchronous reset
    // during ACCESS forces IDLE first, so an aborted write never lands.
    assign ram_we_s = (state_q == ST_ACCESS) && we_q && is_ram_s;

    // Read mux for the latched address; the switch port is sampled here on
    // the ACCESS edge because IO reads go straight from ACCESS to RESP.
    always_comb begin
        rd_val_s = UNMAPPED_RDATA;
        if (is_ram_s) begin
            rd_val_s = mem_q[addr_q[7:0]];
        end else if (is_led_s) begin
            rd_val_s = {8'h00, led_q};
        end else if (is_sw_s) begin
            rd_val_s = {8'h00, sw};
        end else begin
            rd_val_s = UNMAPPED_RDATA;
        end
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        led_d   = led_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                cnt_d = WAIT_LOAD;
                if (is_led_s && we_q) begin
                    led_d = wdata_q[7:0];
                end else begin
                    led_d = led_q;
                end
                if (is_ram_s && HAS_WAIT) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                    // rdata changes only on reads, on the edge entering RESP.
                    if (!we_q) begin
                        rdata_d = rd_val_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = rd_val_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - 2'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ack follows RESP by one edge; busy mirrors the state being entered.
    always_comb begin
        ack_d  = (state_q == ST_RESP);
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 9'h000;
            wdata_q <= 16'h0000;
            cnt_q   <= 2'd0;
            rdata_q <= 16'h0000;
            led_q   <= 8'h00;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[addr_q[7:0]] <= wdata_q;
        end
    end

`ifdef MMIO_ERR_EN
    logic is_unmapped_s;
    logic err_q, err_d;

    assign is_unmapped_s = ~is_ram_s & ~is_led_s & ~is_sw_s;

    // err is raised in the ack cycle of any unmapped access.
    always_comb begin
        err_d = (state_q == ST_RESP) && is_unmapped_s;
    end

    // Registered unmapped-access flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_io_ctrl
//
// Directed bench for mem_io_ctrl with the default RAM_WAIT=1. Each
// transaction is launched in IDLE, the number of edges until ack is
// measured, and rdata/led/err are compared against hand-computed values.
// Latency: RAM = 3 edges after the accepting edge, IO/unmapped = 2.
// ---------------------------------------------------------------------------
module tb_mem_io_ctrl;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] led_pre;
    logic       err_early;
    int         ack_seen;

    localparam int LAT_RAM = 3;
    localparam int LAT_IO  = 2;

`ifdef MMIO_ERR_EN
    localparam logic [15:0] EXP_UNMAP_RD  = 16'hDEAD;
    localparam logic        EXP_UNMAP_ERR = 1'b1;
`else
    localparam logic [15:0] EXP_UNMAP_RD  = 16'h0000;
    localparam logic        EXP_UNMAP_ERR = 1'b0;
`endif

    mem_io_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .busy  (busy),
        .sw    (sw),
        .led   (led),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Launch one transaction and return in its ack cycle (#1 after the edge).
    // With scramble set, the bus is disturbed while the controller is busy.
    task automatic xact(input logic w, input logic [8:0] a, input logic [15:0] d,
                        input int exp_lat, input string tag, input bit scramble);
        int lat;
        lat = 0;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (scramble) begin
            addr  = 9'h030;
            wdata = 16'h5555;
            we    = 1'b1;
        end
        led_pre   = led;
        err_early = 1'b0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = i;
            end else begin
                led_pre = led;
                if (err) err_early = 1'b1;
            end
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_err_early"}, {31'd0, err_early}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 9'h000;
        wdata = 16'h0000;
        sw    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_ack",   {31'd0, ack},  32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_rdata", {16'd0, rdata}, 32'h0000);
        check_eq("rst_led",   {24'd0, led},  32'h00);
        check_eq("rst_err",   {31'd0, err},  32'd0);

        // RAM write then read, with the ack pulse width checked after the read.
        xact(1'b1, 9'h005, 16'h1234, LAT_RAM, "wr005", 1'b0);
        check_eq("wr005_rdata_held", {16'd0, rdata}, 32'h0000);
        xact(1'b0, 9'h005, 16'h0000, LAT_RAM, "rd005", 1'b0);
        check_eq("rd005_rdata", {16'd0, rdata}, 32'h1234);
        @(posedge clk);
        #1;
        check_eq("rd005_ack_pulse", {31'd0, ack}, 32'd0);

        // LED write then read.
        xact(1'b1, 9'h100, 16'h01A5, LAT_IO, "wrled", 1'b0);
        check_eq("wrled_led_pre_ack", {24'd0, led_pre}, 32'hA5);
        check_eq("wrled_rdata_held", {16'd0, rdata}, 32'h1234);
        xact(1'b0, 9'h100, 16'h0000, LAT_IO, "rdled", 1'b0);
        check_eq("rdled_rdata", {16'd0, rdata}, 32'h00A5);

        // Switch port read and ignored write; RAM word 0x40 must not alias.
        xact(1'b1, 9'h040, 16'h0BAD, LAT_RAM, "wr040", 1'b0);
        sw = 8'h3C;
        xact(1'b0, 9'h140, 16'h0000, LAT_IO, "rdsw", 1'b0);
        check_eq("rdsw_rdata", {16'd0, rdata}, 32'h003C);
        xact(1'b1, 9'h140, 16'hFFFF, LAT_IO, "wrsw", 1'b0);
        check_eq("wrsw_err", {31'd0, err}, 32'd0);
        check_eq("wrsw_led", {24'd0, led}, 32'hA5);
        xact(1'b0, 9'h040, 16'h0000, LAT_RAM, "rd040", 1'b0);
        check_eq("rd040_rdata", {16'd0, rdata}, 32'h0BAD);

        // Unmapped read.
        xact(1'b0, 9'h1FF, 16'h0000, LAT_IO, "rd1ff", 1'b0);
        check_eq("rd1ff_rdata", {16'd0, rdata}, {16'd0, EXP_UNMAP_RD});
        check_eq("rd1ff_err", {31'd0, err}, {31'd0, EXP_UNMAP_ERR});
        @(posedge clk);
        #1;
        check_eq("rd1ff_err_after", {31'd0, err}, 32'd0);

        // Reset abort of a RAM write in its ACCESS cycle.
        xact(1'b1, 9'h010, 16'h0001, LAT_RAM, "wr010", 1'b0);
        xact(1'b0, 9'h010, 16'h0000, LAT_RAM, "rd010a", 1'b0);
        check_eq("rd010a_rdata", {16'd0, rdata}, 32'h0001);
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 9'h010;
        wdata = 16'hBEEF;
        @(posedge clk);
        #1;
        req = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_ack",   {31'd0, ack},  32'd0);
        check_eq("abort_busy",  {31'd0, busy}, 32'd0);
        check_eq("abort_rdata", {16'd0, rdata}, 32'h0000);
        check_eq("abort_led",   {24'd0, led},  32'h00);
        check_eq("abort_err",   {31'd0, err},  32'd0);
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ack) ack_seen++;
        end
        check_eq("abort_no_ack", ack_seen, 0);
        xact(1'b0, 9'h010, 16'h0000, LAT_RAM, "rd010b", 1'b0);
        check_eq("rd010b_rdata", {16'd0, rdata}, 32'h0001);

        // Bus changes while busy must not redirect the read or cause a write.
        xact(1'b1, 9'h020, 16'h7777, LAT_RAM, "wr020", 1'b0);
        xact(1'b1, 9'h030, 16'h1111, LAT_RAM, "wr030", 1'b0);
        xact(1'b0, 9'h020, 16'h0000, LAT_RAM, "rd020s", 1'b1);
        check_eq("rd020s_rdata", {16'd0, rdata}, 32'h7777);
        xact(1'b0, 9'h030, 16'h0000, LAT_RAM, "rd030", 1'b0);
        check_eq("rd030_rdata", {16'd0, rdata}, 32'h1111);
        xact(1'b0, 9'h020, 16'h0000, LAT_RAM, "rd020", 1'b0);
        check_eq("rd020_rdata", {16'd0, rdata}, 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
